fifo_uart_tx: RTL
=================

FIFO_UART_TX -- requirements
Module: fifo_uart_tx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 217, i_Clk cycles per UART bit; SHALL be >= 2.
REQ-002 i_Clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 i_Rst  input  1  reset; synchronous and active-high.
REQ-004 i_FIFO_Byte  input  8  head byte of the upstream byte FIFO, valid whenever i_FIFO_Ready_To_Read=1.
REQ-005 i_FIFO_Ready_To_Read  input  1  FIFO non-empty.
REQ-006 o_FIFO_Shift_Now  output  1  one-cycle pop request to the FIFO.
REQ-007 o_TX_Serial  output  1  UART line, idle high.
REQ-008 o_TX_Active  output  1  high while a frame is on the line.
REQ-009 o_TX_Done  output  1  one-cycle pulse after each completed frame.

Function
REQ-010 FSM states SHALL be IDLE, START, DATA, PARITY (macro only), STOP and CLEANUP.
REQ-011 IDLE: o_TX_Serial=1, o_TX_Active=0; if i_FIFO_Ready_To_Read=1, latch i_FIFO_Byte, assert o_FIFO_Shift_Now for that cycle only, and go to START.
REQ-012 o_FIFO_Shift_Now SHALL never assert outside the IDLE fetch cycle, nor while i_FIFO_Ready_To_Read=0.
REQ-013 START: o_TX_Serial=0 for exactly CLKS_PER_BIT cycles, beginning the cycle after the fetch.
REQ-014 DATA: latched bits 0..7 in order (LSB first), each held exactly CLKS_PER_BIT cycles; 3-bit index, no wrap beyond 7.
REQ-015 STOP: o_TX_Serial=1 for exactly CLKS_PER_BIT cycles.
REQ-016 CLEANUP: lasts 1 cycle; o_TX_Serial=1, o_TX_Done=1, o_TX_Active=0; then go to IDLE.
REQ-017 o_TX_Active SHALL be 1 in START, DATA, PARITY and STOP, and 0 otherwise.
REQ-018 The bit-timing counter SHALL count 0..CLKS_PER_BIT-1, be sized for CLKS_PER_BIT-1, and clear on every bit boundary.
REQ-019 FIFO refilling or emptying mid-frame SHALL NOT affect the frame in flight; the latched byte is stable until CLEANUP.
REQ-020 Back-to-back: with the FIFO continuously non-empty, the frame period SHALL be 10*CLKS_PER_BIT+2 cycles (11*CLKS_PER_BIT+2 with the macro).
REQ-021 An empty FIFO in IDLE SHALL leave the block in IDLE with no pop and the line high indefinitely.

Reset
REQ-022 While i_Rst=1: state=IDLE, o_TX_Serial=1, o_TX_Active=0, o_TX_Done=0, o_FIFO_Shift_Now=0, counters=0, latched byte=0.
REQ-023 Reset mid-frame SHALL abort the frame: line high from the next edge, with no o_TX_Done and no pop.
REQ-024 The first fetch is permitted in the first cycle after i_Rst deasserts.

Configuration
REQ-025 Macro FIFO_UART_TX_PARITY_EN defined: PARITY state inserted between DATA and STOP, driving the even-parity bit (XOR of the 8 data bits) for CLKS_PER_BIT cycles.
REQ-026 Macro undefined: no PARITY state or logic; frame is 8N1.

Verification (CLKS_PER_BIT=4)
REQ-027 FIFO holds 0x5A, macro off -> one pop pulse; line 0,0,1,0,1,1,0,1,0,1, each for 4 cycles; o_TX_Done pulses once, 41 cycles after the pop.
REQ-028 FIFO holds 0x01,0x80 -> exactly 2 pops 42 cycles apart; frames carry 0x01 then 0x80; line high between them for 2 cycles.
REQ-029 FIFO empty for 100 cycles -> o_FIFO_Shift_Now=0, o_TX_Serial=1, o_TX_Active=0 throughout.
REQ-030 i_Rst pulsed 1 cycle at cycle 15 of a 0xFF frame -> line high and o_TX_Active=0 next cycle; no o_TX_Done; next byte fetched after reset.
REQ-031 Macro on, byte 0x07 -> parity bit 1 for 4 cycles before stop; byte 0x03 -> parity bit 0; frame period 46 cycles.
REQ-032 i_FIFO_Ready_To_Read drops in the cycle after the pop -> the frame completes unchanged and no further pop occurs.

Source files
------------

// File: rtl/fifo_uart_tx_if.sv
// FIFO-read and UART-line signal bundle for fifo_uart_tx.
// slave is the transmitter's view; master is the FIFO/line side.
interface fifo_uart_tx_if;
    logic [7:0] i_FIFO_Byte;
    logic       i_FIFO_Ready_To_Read;
    logic       o_FIFO_Shift_Now;
    logic       o_TX_Serial;
    logic       o_TX_Active;
    logic       o_TX_Done;

    modport slave (
        input  i_FIFO_Byte,
        input  i_FIFO_Ready_To_Read,
        output o_FIFO_Shift_Now,
        output o_TX_Serial,
        output o_TX_Active,
        output o_TX_Done
    );

    modport master (
        output i_FIFO_Byte,
        output i_FIFO_Ready_To_Read,
        input  o_FIFO_Shift_Now,
        input  o_TX_Serial,
        input  o_TX_Active,
        input  o_TX_Done
    );
endinterface

// File: rtl/fifo_uart_tx.sv
// UART transmitter that pulls bytes from an upstream FIFO and sends 8N1 frames.
// Define FIFO_UART_TX_PARITY_EN to insert an even-parity bit (8E1).
module fifo_uart_tx #(
    parameter int CLKS_PER_BIT = 217
) (
    input  logic           i_Clk,
    input  logic           i_Rst,
    fifo_uart_tx_if.slave  bus
);
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_START   = 3'd1,
        S_DATA    = 3'd2,
`ifdef FIFO_UART_TX_PARITY_EN
        S_PARITY  = 3'd3,
`endif
        S_STOP    = 3'd4,
        S_CLEANUP = 3'd5
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       data_q, data_d;
    logic             serial_q, serial_d;
    logic             active_q, active_d;
    logic             done_q, done_d;
    logic             shift_now_s;
    logic             bit_end_s;

    assign bit_end_s = (cnt_q == CNT_MAX);

    // Next-state, bit timing and byte latch.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bit_idx_d   = bit_idx_q;
        data_d      = data_q;
        shift_now_s = 1'b0;
        case (state_q)
            S_IDLE: begin
                cnt_d     = '0;
                bit_idx_d = 3'd0;
                if (bus.i_FIFO_Ready_To_Read) begin
                    data_d      = bus.i_FIFO_Byte;
                    shift_now_s = 1'b1;
                    state_d     = S_START;
                end else begin
                    state_d     = S_IDLE;
                end
            end
            S_START: begin
                if (bit_end_s) begin
                    cnt_d   = '0;
                    state_d = S_DATA;
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
                end
            end
            S_DATA: begin
                if (bit_end_s) begin
                    cnt_d = '0;
                    if (bit_idx_q == 3'd7) begin
                        bit_idx_d = 3'd0;
`ifdef FIFO_UART_TX_PARITY_EN
                        state_d   = S_PARITY;
`else
                        state_d   = S_STOP;
`endif
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
`ifdef FIFO_UART_TX_PARITY_EN
            S_PARITY: begin
                if (bit_end_s) begin
                    cnt_d   = '0;
                    state_d = S_STOP;
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
                end
            end
`endif
            S_STOP: begin
                if (bit_end_s) begin
                    cnt_d   = '0;
                    state_d = S_CLEANUP;
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
                end
            end
            S_CLEANUP: begin
                cnt_d   = '0;
                state_d = S_IDLE;
            end
            default: begin
                cnt_d     = '0;
                bit_idx_d = 3'd0;
                state_d   = S_IDLE;
            end
        endcase
    end

    // Line outputs decoded from the next state so they register in step with it.
    always_comb begin
        serial_d = 1'b1;
        active_d = 1'b0;
        done_d   = 1'b0;
        case (state_d)
            S_START: begin
                serial_d = 1'b0;
                active_d = 1'b1;
            end
            S_DATA: begin
                serial_d = data_d[bit_idx_d];
                active_d = 1'b1;
            end
`ifdef FIFO_UART_TX_PARITY_EN
            S_PARITY: begin
                serial_d = ^data_d;
                active_d = 1'b1;
            end
`endif
            S_STOP: begin
                serial_d = 1'b1;
                active_d = 1'b1;
            end
            S_CLEANUP: begin
                serial_d = 1'b1;
                done_d   = 1'b1;
            end
            default: begin
                serial_d = 1'b1;
                active_d = 1'b0;
                done_d   = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            bit_idx_q <= 3'd0;
            data_q    <= 8'h00;
            serial_q  <= 1'b1;
            active_q  <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            data_q    <= data_d;
            serial_q  <= serial_d;
            active_q  <= active_d;
            done_q    <= done_d;
        end
    end

    // The pop must coincide with the fetch cycle, so it stays combinational.
    assign bus.o_FIFO_Shift_Now = shift_now_s & ~i_Rst;
    assign bus.o_TX_Serial      = serial_q;
    assign bus.o_TX_Active      = active_q;
    assign bus.o_TX_Done        = done_q;
endmodule
